truth_table_extractor: RTL and testbench
========================================

Name: truth_table_extractor

Overview:
Sequential characteriser for 3-input logic circuits under test (CUT).
- Drives all 8 input combinations onto a CUT's in1/in2/in3 and waits a programmable settle time after each one.
- Samples the CUT output and assembles the 8-bit truth-table code, using the same hex naming as the circuit library (e.g. 0xA0).
- Compares the code against an expected value, so bench and hardware flows can confirm a synthesized circuit realises its intended function.

Parameters:
SETTLE_CYCLES, 4, clocks each combination is held before sampling; legal range 1..255.
CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  single system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a characterisation run; sampled only in IDLE.
abort  input  1  synchronous cancel of a run in progress.
expected_code  input  8  reference truth-table code, sampled on the start-accepting edge.
cut_out  input  1  output of the circuit under test.
drive_in1  output  1  CUT input in1 (MSB of combination index).
drive_in2  output  1  CUT input in2.
drive_in3  output  1  CUT input in3 (LSB).
busy  output  1  high from the start-accepting edge until return to IDLE.
done  output  1  one-cycle pulse when tt_code is final.
tt_valid  output  1  tt_code/match hold a completed result.
tt_code  output  8  assembled truth-table code.
match  output  1  tt_code == latched expected_code; meaningful only while tt_valid=1.
glitch  output  1  optional-feature flag; constant 0 when the feature is compiled out.

Behaviour:
Reset and clock:
- Clock is clk; reset is rst_n, asynchronous active-low.
- Reset value of every output is 0: drive_in*=000, busy=0, done=0, tt_valid=0, tt_code=0x00, match=0, glitch=0.
- Internal state on reset: state=IDLE, idx=0, cnt=0, latched expected=0x00.

Encoding:
- Combination index idx = {in1,in2,in3}.
- tt_code bit (7-idx) = cut_out sampled for idx, so idx 000 maps to the MSB.
- Example: out=1 only at 000 and 010 gives 0xA0.

FSM states IDLE, SETTLE, SAMPLE, DONE:
- IDLE: drive_in*=000. On start=1: latch expected_code, clear tt_valid/tt_code/match/glitch, set busy, idx=0, cnt=0, go to SETTLE.
- SETTLE: drive_in*=idx (registered). cnt increments each clock. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: capture cut_out into tt_code[7-idx].
  - If idx==7, go to DONE.
  - Otherwise idx+1, cnt=0, go to SETTLE.
- DONE: done=1 for exactly this cycle, tt_valid=1, match=(tt_code==latched expected). Next clock goes to IDLE; busy falls on that edge.

Latency:
- Each combination occupies SETTLE_CYCLES+1 clocks.
- done is high in the cycle following edge 8*(SETTLE_CYCLES+1) after the start-accepting edge (edge 40 for the default).

Boundary conditions:
- start while busy: ignored.
- start held high continuously: a new run begins on the clock after DONE returns to IDLE.
- abort=1 in SETTLE/SAMPLE: next edge goes to IDLE, drive_in*=000, busy=0, tt_valid=0, no done pulse.
- abort in DONE: ignored; the result completes.
- abort and start together in IDLE: start wins; abort has no effect in IDLE.
- rst_n low mid-run: immediate return to reset values, no done pulse.
- After a run: tt_valid, tt_code and match hold until the next accepted start or reset.
- idx does not wrap; the run terminates at idx 7.

Optional Feature:
TT_GLITCH_CHECK_EN
- Defined:
  - cut_out is additionally sampled on the SETTLE cycle where cnt==SETTLE_CYCLES-1.
  - If that sample differs from the SAMPLE-state value for any combination, glitch is set; it is sticky until the next accepted start or reset.
  - Setting glitch forces match=0 at DONE.
- Undefined: no extra sample logic; glitch is tied to 0; match depends only on the code comparison.

Test Plan:
- CUT model 0xA0 (out=1 for 000,010), expected_code=0xA0, start pulse → done exactly 40 clocks after the accept edge; tt_code=0xA0, match=1, tt_valid=1; drive_in* steps 000..111, each held 5 clocks.
- CUT tied to 1, expected_code=0xA0 → tt_code=0xFF, match=0, done pulse one cycle wide.
- Start re-pulsed at clock 10 of a run → ignored; single done at clock 40; tt_code unchanged from the correct value.
- Abort at clock 17 → busy=0 next cycle, tt_valid=0, no done; new start then completes normally with 0xA0.
- rst_n asserted low at clock 23 (asynchronous, mid-clock) → all outputs 0 immediately; after release, a fresh run yields correct code.
- With TT_GLITCH_CHECK_EN, CUT output toggled between the pre-sample and the sample for idx 3 → glitch=1, match=0 even when tt_code equals expected.

Source files
------------

// File: rtl/truth_table_extractor.sv
// Steps a 3-input CUT through all 8 input combinations and assembles its truth-table code.
// Optional glitch check (pre-sample vs. sample comparison) enabled by TT_GLITCH_CHECK_EN.
module truth_table_extractor #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected_code,
   input  logic       cut_out,
   output logic       drive_in1,
   output logic       drive_in2,
   output logic       drive_in3,
   output logic       busy,
   output logic       done,
   output logic       tt_valid,
   output logic [7:0] tt_code,
   output logic       match,
   output logic       glitch
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [2:0]       IDX_LAST = 3'd7;

   logic [1:0]       r_state;
   logic [2:0]       r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_exp;
   logic [2:0]       r_drive;
   logic             r_busy;
   logic             r_done;
   logic             r_valid;
   logic [7:0]       r_code;
   logic             r_match;

   logic [1:0]       w_state_nxt;
   logic [2:0]       w_idx_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       w_exp_nxt;
   logic [2:0]       w_drive_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_valid_nxt;
   logic [7:0]       w_code_nxt;
   logic             w_match_nxt;

`ifdef TT_GLITCH_CHECK_EN
   logic r_pre;
   logic r_glitch;
   logic w_pre_nxt;
   logic w_glitch_nxt;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= 3'd0;
         r_cnt   <= '0;
         r_exp   <= 8'h00;
         r_drive <= 3'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         r_code  <= 8'h00;
         r_match <= 1'b0;
`ifdef TT_GLITCH_CHECK_EN
         r_pre    <= 1'b0;
         r_glitch <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_exp   <= w_exp_nxt;
         r_drive <= w_drive_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_valid <= w_valid_nxt;
         r_code  <= w_code_nxt;
         r_match <= w_match_nxt;
`ifdef TT_GLITCH_CHECK_EN
         r_pre    <= w_pre_nxt;
         r_glitch <= w_glitch_nxt;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_exp_nxt   = r_exp;
      w_drive_nxt = r_drive;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_valid_nxt = r_valid;
      w_code_nxt  = r_code;
      w_match_nxt = r_match;
`ifdef TT_GLITCH_CHECK_EN
      w_pre_nxt    = r_pre;
      w_glitch_nxt = r_glitch;
`endif

      case (r_state)
         S_IDLE: begin
            w_drive_nxt = 3'd0;
            if (start) begin
               w_exp_nxt   = expected_code;
               w_valid_nxt = 1'b0;
               w_code_nxt  = 8'h00;
               w_match_nxt = 1'b0;
               w_busy_nxt  = 1'b1;
               w_idx_nxt   = 3'd0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SETTLE;
`ifdef TT_GLITCH_CHECK_EN
               w_glitch_nxt = 1'b0;
`endif
            end
         end
         S_SETTLE: begin
            w_drive_nxt = r_idx;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_SAMPLE;
`ifdef TT_GLITCH_CHECK_EN
               w_pre_nxt = cut_out;
`endif
            end
         end
         S_SAMPLE: begin
            // idx 000 lands in the MSB, matching the library's hex naming
            w_code_nxt[IDX_LAST - r_idx] = cut_out;
`ifdef TT_GLITCH_CHECK_EN
            if (cut_out != r_pre) begin
               w_glitch_nxt = 1'b1;
            end
`endif
            if (r_idx == IDX_LAST) begin
               w_state_nxt = S_DONE;
               w_drive_nxt = 3'd0;
               w_done_nxt  = 1'b1;
               w_valid_nxt = 1'b1;
`ifdef TT_GLITCH_CHECK_EN
               w_match_nxt = (w_code_nxt == r_exp) && !w_glitch_nxt;
`else
               w_match_nxt = (w_code_nxt == r_exp);
`endif
            end else begin
               w_idx_nxt   = r_idx + 3'd1;
               w_cnt_nxt   = '0;
               w_drive_nxt = r_idx + 3'd1;
               w_state_nxt = S_SETTLE;
            end
         end
         S_DONE: begin
            w_drive_nxt = 3'd0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_drive_nxt = 3'd0;
            w_busy_nxt  = 1'b0;
         end
      endcase

      // Abort cancels only an active sweep; DONE always completes
      if (abort && (r_state == S_SETTLE || r_state == S_SAMPLE)) begin
         w_state_nxt = S_IDLE;
         w_idx_nxt   = 3'd0;
         w_cnt_nxt   = '0;
         w_drive_nxt = 3'd0;
         w_busy_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
         w_valid_nxt = 1'b0;
         w_match_nxt = 1'b0;
      end
   end

   assign drive_in1 = r_drive[2];
   assign drive_in2 = r_drive[1];
   assign drive_in3 = r_drive[0];
   assign busy      = r_busy;
   assign done      = r_done;
   assign tt_valid  = r_valid;
   assign tt_code   = r_code;
   assign match     = r_match;
`ifdef TT_GLITCH_CHECK_EN
   assign glitch    = r_glitch;
`else
   assign glitch    = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Self-checking bench for truth_table_extractor: vector table, corner sequences and random CUTs.
module tb_truth_table_extractor;

   localparam int unsigned SETTLE = 4;
   localparam int unsigned PER    = SETTLE + 1;
   localparam int unsigned LAST   = 8 * PER;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] expected_code;
   logic       cut_out;
   logic       drive_in1, drive_in2, drive_in3;
   logic       busy, done, tt_valid, match, glitch;
   logic [7:0] tt_code;

   // CUT model: cut_fn[k] is the output for combination index k
   bit         cut_fn [8];
   logic       ovr_en;
   logic       ovr_val;
   logic [2:0] w_drv;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] fn;
      logic [7:0] ex;
      logic [7:0] code;
      logic       m;
   } vec_t;

   vec_t vecs [7];

   assign w_drv   = {drive_in1, drive_in2, drive_in3};
   assign cut_out = ovr_en ? ovr_val : cut_fn[w_drv];

   always #5 clk = ~clk;

   truth_table_extractor #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .expected_code (expected_code),
      .cut_out       (cut_out),
      .drive_in1     (drive_in1),
      .drive_in2     (drive_in2),
      .drive_in3     (drive_in3),
      .busy          (busy),
      .done          (done),
      .tt_valid      (tt_valid),
      .tt_code       (tt_code),
      .match         (match),
      .glitch        (glitch)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_code();
      logic [7:0] code = 8'h00;
      for (int k = 0; k < 8; k++)
         if (cut_fn[k]) code = code + 8'(1 << (7 - k));
      return code;
   endfunction

   task automatic set_fn(input logic [7:0] fn);
      for (int k = 0; k < 8; k++) cut_fn[k] = fn[k];
   endtask

   task automatic start_run(input logic [7:0] ex, input logic ab);
      @(negedge clk);
      expected_code = ex;
      start = 1'b1;
      abort = ab;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Follows a run from 1ns after the accept edge (n=0) through edge LAST+3
   task automatic watch(input logic [7:0] ecode, input logic em, input logic eg,
                        input int repulse_at, input int glitch_at);
      for (int n = 0; n <= int'(LAST) + 3; n++) begin
         chk("drive", 8'(w_drv), (n < int'(LAST)) ? 8'(n / int'(PER)) : 8'h00);
         chk("busy", 8'(busy), 8'(n <= int'(LAST)));
         chk("done", 8'(done), 8'(n == int'(LAST)));
         if (n < int'(LAST)) begin
            chk("valid_low", 8'(tt_valid), 8'h00);
         end else begin
            chk("valid", 8'(tt_valid), 8'h01);
            chk("code", tt_code, ecode);
            chk("match", 8'(match), 8'(em));
            chk("glitch", 8'(glitch), 8'(eg));
         end
         start   = (n == repulse_at);
         ovr_en  = (n == glitch_at);
         ovr_val = ~cut_fn[3];
         @(posedge clk);
         #1;
      end
      start  = 1'b0;
      ovr_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ex, mc;
      int         seen;

      vecs[0] = '{8'h05, 8'hA0, 8'hA0, 1'b1};   // out=1 at 000 and 010
      vecs[1] = '{8'hFF, 8'hA0, 8'hFF, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b1};
      vecs[3] = '{8'h80, 8'h01, 8'h01, 1'b1};   // only 111
      vecs[4] = '{8'h01, 8'h80, 8'h80, 1'b1};   // only 000
      vecs[5] = '{8'h69, 8'h96, 8'h96, 1'b1};
      vecs[6] = '{8'h0F, 8'hF1, 8'hF0, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      expected_code = 8'h00;
      ovr_en = 1'b0;
      ovr_val = 1'b0;
      set_fn(8'h05);
      #2;
      chk("rst_drive", 8'(w_drv), 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
      chk("rst_done", 8'(done), 8'h00);
      chk("rst_valid", 8'(tt_valid), 8'h00);
      chk("rst_code", tt_code, 8'h00);
      chk("rst_match", 8'(match), 8'h00);
      chk("rst_glitch", 8'(glitch), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table
      foreach (vecs[i]) begin
         set_fn(vecs[i].fn);
         start_run(vecs[i].ex, 1'b0);
         watch(vecs[i].code, vecs[i].m, 1'b0, -1, -1);
      end

      // Start re-pulsed mid-run is ignored
      set_fn(8'h05);
      start_run(8'hA0, 1'b0);
      watch(8'hA0, 1'b1, 1'b0, 10, -1);

      // Abort at clock 17, then a normal run
      start_run(8'hA0, 1'b0);
      repeat (17) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", 8'(busy), 8'h00);
      chk("abort_valid", 8'(tt_valid), 8'h00);
      chk("abort_drive", 8'(w_drv), 8'h00);
      seen = 0;
      repeat (LAST) begin
         if (done || busy) seen++;
         @(posedge clk); #1;
      end
      chk("abort_quiet", 8'(seen), 8'h00);
      start_run(8'hA0, 1'b0);
      watch(8'hA0, 1'b1, 1'b0, -1, -1);

      // Abort during DONE is ignored
      start_run(8'hA0, 1'b0);
      repeat (LAST) begin @(posedge clk); #1; end
      chk("dabort_done", 8'(done), 8'h01);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("dabort_valid", 8'(tt_valid), 8'h01);
      chk("dabort_code", tt_code, 8'hA0);
      chk("dabort_match", 8'(match), 8'h01);
      chk("dabort_busy", 8'(busy), 8'h00);

      // Start and abort together in IDLE: start wins
      start_run(8'hA0, 1'b1);
      watch(8'hA0, 1'b1, 1'b0, -1, -1);

      // Start held high: next run begins the clock after returning to IDLE
      @(negedge clk);
      expected_code = 8'hA0;
      start = 1'b1;
      @(posedge clk); #1;
      repeat (LAST) begin @(posedge clk); #1; end
      chk("hold_done", 8'(done), 8'h01);
      @(posedge clk); #1;
      chk("hold_idle_busy", 8'(busy), 8'h00);
      chk("hold_idle_valid", 8'(tt_valid), 8'h01);
      @(posedge clk); #1;
      chk("hold_restart_busy", 8'(busy), 8'h01);
      chk("hold_restart_valid", 8'(tt_valid), 8'h00);
      start = 1'b0;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("hold_abort_busy", 8'(busy), 8'h00);

      // Asynchronous reset mid-clock at clock 23
      start_run(8'hA0, 1'b0);
      repeat (23) begin @(posedge clk); #1; end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_drive", 8'(w_drv), 8'h00);
      chk("arst_busy", 8'(busy), 8'h00);
      chk("arst_done", 8'(done), 8'h00);
      chk("arst_code", tt_code, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      start_run(8'hA0, 1'b0);
      watch(8'hA0, 1'b1, 1'b0, -1, -1);

`ifdef TT_GLITCH_CHECK_EN
      // Output toggled between pre-sample and sample of idx 3
      start_run(8'hA0, 1'b0);
      watch(8'hA0, 1'b0, 1'b1, -1, 3 * int'(PER) + SETTLE - 1);
`endif

      // Random CUTs against the reference model
      for (int r = 0; r < 6; r++) begin
         set_fn(8'($urandom));
         mc = model_code();
         ex = ($urandom_range(0, 1) == 1) ? mc : 8'($urandom);
         start_run(ex, 1'b0);
         watch(mc, mc == ex, 1'b0, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
